// File: rtl/mux_lane_arbiter.sv
// Round-robin arbiter that shares one output lane among four requesters.
// It grants bursts of up to MAX_BURST beats and inserts one idle turnaround cycle between grants.
module mux_lane_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] sel_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] count, count_nxt;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       xfer;

  // The scan starts one past the last winner, so the previous owner is checked last.
  always_comb begin
    winner = ptr + 2'd1;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign out_valid = rst_n && (state == BUSY) && req[sel];
  assign xfer      = out_valid && out_ready;
  assign busy      = (state == BUSY);

  always_comb begin
    case (sel)
      2'd0:    out_data = data0;
      2'd1:    out_data = data1;
      2'd2:    out_data = data2;
      default: out_data = data3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (req != 4'd0) begin
          state_nxt = BUSY;
          gnt_nxt   = 4'b0001 << winner;
          sel_nxt   = winner;
          ptr_nxt   = winner;
          count_nxt = 8'd0;
        end
      end
      BUSY: begin
        if (!req[sel] || (xfer && count == LAST_BEAT)) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'd0;
          count_nxt = 8'd0;
        end else if (xfer) begin
          count_nxt = count + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'd0;
        count_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'd0;
      sel   <= 2'd0;
      ptr   <= 2'd3;
      count <= 8'd0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_mux_lane_arbiter.sv
// Bench for mux_lane_arbiter: directed scenarios plus a randomized run.
// The random run is checked against a grant-holder/beats-left reference model.
module tb_mux_lane_arbiter;

  localparam int WIDTH = 4;
  localparam int MAXB  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = 4'd0;
  logic [WIDTH-1:0] d [4];
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: who owns the lane and how many beats it has left.
  bit m_busy;
  int m_sel, m_ptr, m_left;

  mux_lane_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
    .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int win;
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_ptr = 3; m_left = MAXB;
    end else if (!m_busy) begin
      if (req != 4'd0) begin
        win = -1;
        for (int k = 1; k <= 4; k++)
          if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        m_busy = 1; m_sel = win; m_ptr = win; m_left = MAXB;
      end
    end else if (!req[m_sel]) begin
      m_busy = 0;
    end else if (out_ready) begin
      m_left = m_left - 1;
      if (m_left == 0) m_busy = 0;
    end
  endtask

  // Advance one clock, then apply new inputs and settle before checking.
  task automatic cyc(input logic rn, input logic [3:0] r, input logic rdy);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst_n = rn; req = r; out_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    cyc(1'b0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b1111, 1'b1);
    n_cmp++; if (gnt !== 4'd0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    cyc(1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_single();
    int beats = 0;
    d[0] = 4'hA;
    cyc(1'b1, 4'b0001, 1'b1);
    n_cmp++; if (gnt !== 4'd0) begin n_fail++; $display("FAIL single_nogrant_yet: got %b want 0000", gnt); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'b0001, 1'b1);
      n_cmp++; if (gnt !== 4'b0001 || out_data !== 4'hA || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL single_beat%0d: got gnt=%b data=%h vld=%b want 0001/a/1", i, gnt, out_data, out_valid);
      end
      if (out_valid && out_ready) beats++;
    end
    cyc(1'b1, 4'b0000, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_drop: got vld=%b busy=%b want 0/1", out_valid, busy); end
    cyc(1'b1, 4'b0000, 1'b1);
    n_cmp++; if (gnt !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    n_cmp++; if (beats != 3) begin n_fail++; $display("FAIL single_beats: got %0d want 3", beats); end
  endtask

  task automatic test_all_rotate();
    int g;
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 4'b1111, 1'b1);
    for (int c = 0; c < 25; c++) begin
      if (c > 0) cyc(1'b1, 4'b1111, 1'b1);
      g = (c / 5) % 4;
      if (c % 5 == 0) begin
        n_cmp++; if (busy !== 1'b0 || gnt !== 4'd0) begin n_fail++; $display("FAIL rotate_gap c=%0d: got busy=%b gnt=%b want 0/0000", c, busy, gnt); end
      end else begin
        n_cmp++; if (busy !== 1'b1 || sel !== 2'(g) || gnt !== (4'b0001 << g) || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL rotate_grant c=%0d: got busy=%b sel=%0d gnt=%b vld=%b want sel=%0d", c, busy, sel, gnt, out_valid, g);
        end
      end
    end
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_backpressure();
    logic rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int acc = 0;
    d[2] = 4'h5;
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0100, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 4'b0100, rdy[i]);
      n_cmp++; if (busy !== 1'b1 || sel !== 2'd2 || out_data !== 4'h5 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold i=%0d: got busy=%b sel=%0d data=%h vld=%b want 1/2/5/1", i, busy, sel, out_data, out_valid);
      end
      if (out_valid && out_ready) acc++;
    end
    n_cmp++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    cyc(1'b1, 4'b0100, 1'b1);
    n_cmp++; if (busy !== 1'b0 || gnt !== 4'd0) begin n_fail++; $display("FAIL bp_release: got busy=%b gnt=%b want 0/0000", busy, gnt); end
    cyc(1'b1, 4'b0000, 1'b1);
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL bp_regrant: got %b want 0100", gnt); end
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_priority();
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0010, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    n_cmp++; if (sel !== 2'd1) begin n_fail++; $display("FAIL prio_first: got sel=%0d want 1", sel); end
    cyc(1'b1, 4'b0011, 1'b1);
    cyc(1'b1, 4'b0011, 1'b1);
    n_cmp++; if (gnt !== 4'b0001 || sel !== 2'd0) begin n_fail++; $display("FAIL prio_next: got gnt=%b sel=%0d want 0001/0", gnt, sel); end
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_early_drop();
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 4'b1000, 1'b1);
    cyc(1'b1, 4'b1000, 1'b1);
    cyc(1'b1, 4'b1000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_valid: got vld=%b gnt=%b want 0/1000", out_valid, gnt); end
    cyc(1'b1, 4'b1000, 1'b1);
    n_cmp++; if (gnt !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    // A fresh grant must get a full burst, so the discarded count cannot leak.
    for (int i = 0; i < MAXB; i++) cyc(1'b1, 4'b1000, 1'b1);
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL drop_fullburst: got busy=%b vld=%b want 1/1", busy, out_valid); end
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0100, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0010, 1'b1);
    cyc(1'b1, 4'b0010, 1'b1);
    cyc(1'b0, 4'b0010, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    cyc(1'b1, 4'b0010, 1'b1);
    n_cmp++; if (gnt !== 4'd0 || sel !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got gnt=%b sel=%0d busy=%b want 0000/0/0", gnt, sel, busy); end
    cyc(1'b1, 4'b0010, 1'b1);
    n_cmp++; if (gnt !== 4'b0010 || sel !== 2'd1) begin n_fail++; $display("FAIL rstmid_regrant: got gnt=%b sel=%0d want 0010/1", gnt, sel); end
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       exp_vld;
    logic [3:0] exp_gnt;
    for (int i = 0; i < 1500; i++) begin
      for (int j = 0; j < 4; j++) d[j] = 4'($urandom);
      r = 4'($urandom);
      if ($urandom_range(3, 0) == 0) r = 4'd0;
      cyc(($urandom_range(99, 0) != 0), r, ($urandom_range(3, 0) != 0));
      exp_vld = rst_n && m_busy && req[m_sel];
      exp_gnt = m_busy ? (4'b0001 << m_sel) : 4'd0;
      n_cmp++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt i=%0d: got %b want %b", i, gnt, exp_gnt); end
      n_cmp++; if (sel !== 2'(m_sel)) begin n_fail++; $display("FAIL rand_sel i=%0d: got %0d want %0d", i, sel, m_sel); end
      n_cmp++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy i=%0d: got %b want %b", i, busy, m_busy); end
      n_cmp++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL rand_valid i=%0d: got %b want %b", i, out_valid, exp_vld); end
      n_cmp++; if (out_data !== d[m_sel]) begin n_fail++; $display("FAIL rand_data i=%0d: got %h want %h", i, out_data, d[m_sel]); end
    end
  endtask

  initial begin
    for (int j = 0; j < 4; j++) d[j] = 4'(j + 1);
    m_busy = 0; m_sel = 0; m_ptr = 3; m_left = MAXB;
    test_reset();
    test_single();
    test_all_rotate();
    test_backpressure();
    test_priority();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
